// File: rtl/obi_mem_device.sv
// OBI responder in front of a 64-bit-wide RAM. It grants requests after a
// programmable number of wait cycles and limits how many granted transactions
// may be waiting for a response. Responses return in order after a fixed latency.
module obi_mem_device #(
    parameter int DEPTH_WORDS     = 1024,
    parameter int GNT_WAIT        = 0,
    parameter int RESP_LAT        = 1,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_i,
    output logic        gnt_o,
    input  logic [63:0] addr_i,
    input  logic        we_i,
    input  logic [7:0]  be_i,
    input  logic [63:0] wdata_i,
    output logic        rvalid_o,
    output logic [63:0] rdata_o,
    output logic        err_o
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = $clog2(GNT_WAIT + 2);
    localparam int OW = $clog2(MAX_OUTSTANDING + 2);
    localparam logic [CW-1:0] WAIT_DONE = CW'(GNT_WAIT);
    localparam logic [OW-1:0] OUT_MAX   = OW'(MAX_OUTSTANDING);
    localparam logic [60:0]   LINES     = 61'(DEPTH_WORDS);

    typedef enum logic {
        IDLE,
        WAIT
    } state_e;

    state_e          state;
    logic [CW-1:0]   wait_cnt;
    logic [OW-1:0]   outstanding;
    logic [63:0]     mem [DEPTH_WORDS];

    logic [AW-1:0]   idx;
    logic            out_of_range;
    logic            wait_done;
    logic            slot_free;
    logic            accept;
    logic            unused_offset;

    // Response pipeline: stage 0 is loaded at the accept edge, last stage drives the outputs.
    logic            vld_p  [RESP_LAT];
    logic            err_p  [RESP_LAT];
    logic [63:0]     data_p [RESP_LAT];

    // Replace the byte lanes selected by be with the new data, keep the rest.
    function automatic logic [63:0] merge_bytes(input logic [63:0] old_line,
                                                input logic [63:0] new_line,
                                                input logic [7:0]  be);
        logic [63:0] res;
        res = old_line;
        for (int k = 0; k < 8; k++) begin
            if (be[k]) res[8*k +: 8] = new_line[8*k +: 8];
        end
        return res;
    endfunction

    assign idx           = addr_i[3+AW-1:3];
    assign out_of_range  = addr_i[63:3] >= LINES;
    assign unused_offset = ^addr_i[2:0];

    // In IDLE the counter is zero, so only a zero-wait configuration may grant there.
    assign wait_done = (state == IDLE) ? (GNT_WAIT == 0) : (wait_cnt == WAIT_DONE);
    // A response leaving this cycle frees its slot for a same-cycle grant.
    assign slot_free = (outstanding < OUT_MAX) || vld_p[RESP_LAT-1];
    assign gnt_o     = rst_ni && req_i && wait_done && slot_free;
    assign accept    = gnt_o;

    // Grant FSM: track how long req_i has been held since the last accept.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state    <= IDLE;
            wait_cnt <= '0;
        end else if (!req_i) begin
            state    <= IDLE;
            wait_cnt <= '0;
        end else begin
            state <= WAIT;
            if (accept) begin
                wait_cnt <= '0;
            end else if (wait_cnt != WAIT_DONE) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
        end
    end

    // Count granted transactions whose response has not yet been delivered.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            outstanding <= '0;
        end else begin
            case ({accept, vld_p[RESP_LAT-1]})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: outstanding <= outstanding;
            endcase
        end
    end

    // Byte-enabled RAM write at the accept edge; contents survive reset.
    always_ff @(posedge clk_i) begin
        if (accept && we_i && !out_of_range) begin
            mem[idx] <= merge_bytes(mem[idx], wdata_i, be_i);
        end
    end

    // Response shift register; idle stages carry zero data so outputs read 0 when invalid.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < RESP_LAT; i++) begin
                vld_p[i]  <= 1'b0;
                err_p[i]  <= 1'b0;
                data_p[i] <= '0;
            end
        end else begin
            vld_p[0]  <= accept;
            err_p[0]  <= accept && out_of_range;
            data_p[0] <= (accept && !we_i && !out_of_range) ? mem[idx] : '0;
            for (int i = 1; i < RESP_LAT; i++) begin
                vld_p[i]  <= vld_p[i-1];
                err_p[i]  <= err_p[i-1];
                data_p[i] <= data_p[i-1];
            end
        end
    end

    assign rvalid_o = vld_p[RESP_LAT-1];
    assign err_o    = err_p[RESP_LAT-1];
    assign rdata_o  = data_p[RESP_LAT-1];

endmodule

// File: tb/tb_obi_mem_device.sv
// Bench for obi_mem_device: three instances with different wait/latency settings,
// directed scenarios followed by random traffic, all checked against a
// transaction-level memory model with a due-cycle response table.
module tb_obi_mem_device;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req    [3];
    logic        gnt    [3];
    logic [63:0] addr   [3];
    logic        we     [3];
    logic [7:0]  be     [3];
    logic [63:0] wdata  [3];
    logic        rvalid [3];
    logic [63:0] rdata  [3];
    logic        err    [3];

    always #5 clk = ~clk;

    obi_mem_device #(.DEPTH_WORDS(DEPTH), .GNT_WAIT(0), .RESP_LAT(1), .MAX_OUTSTANDING(2)) u_dev0 (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req[0]), .gnt_o(gnt[0]), .addr_i(addr[0]),
        .we_i(we[0]), .be_i(be[0]), .wdata_i(wdata[0]), .rvalid_o(rvalid[0]),
        .rdata_o(rdata[0]), .err_o(err[0]));

    obi_mem_device #(.DEPTH_WORDS(DEPTH), .GNT_WAIT(3), .RESP_LAT(1), .MAX_OUTSTANDING(2)) u_dev1 (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req[1]), .gnt_o(gnt[1]), .addr_i(addr[1]),
        .we_i(we[1]), .be_i(be[1]), .wdata_i(wdata[1]), .rvalid_o(rvalid[1]),
        .rdata_o(rdata[1]), .err_o(err[1]));

    obi_mem_device #(.DEPTH_WORDS(DEPTH), .GNT_WAIT(0), .RESP_LAT(3), .MAX_OUTSTANDING(2)) u_dev2 (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req[2]), .gnt_o(gnt[2]), .addr_i(addr[2]),
        .we_i(we[2]), .be_i(be[2]), .wdata_i(wdata[2]), .rvalid_o(rvalid[2]),
        .rdata_o(rdata[2]), .err_o(err[2]));

    // Per-instance configuration mirrored in the model
    int GW  [3] = '{0, 3, 0};
    int LAT [3] = '{1, 1, 3};
    int MO  [3] = '{2, 2, 2};

    // Reference model: memory image, responses keyed by the cycle they are due
    logic [63:0] mem_m [3][DEPTH];
    bit          rv_m  [3][8];
    bit          er_m  [3][8];
    logic [63:0] rd_m  [3][8];
    int          held  [3];
    bit          acc   [3];

    // Observation logs for timing checks
    int          gcyc  [3][32];
    int          gn    [3];
    int          rcyc  [3][32];
    int          rn    [3];
    logic [63:0] last_rd [3];
    logic        last_er [3];

    int cyc    = 0;
    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < 3; i++) begin
            held[i] = 0;
            acc[i]  = 1'b0;
            for (int s = 0; s < 8; s++) begin
                rv_m[i][s] = 1'b0;
                er_m[i][s] = 1'b0;
                rd_m[i][s] = '0;
            end
        end
    endtask

    task automatic clear_logs();
        for (int i = 0; i < 3; i++) begin
            gn[i] = 0;
            rn[i] = 0;
        end
    endtask

    // One clock cycle: check every instance at the falling edge, advance the model.
    task automatic tick();
        int          slot, nslot, pend;
        logic        eg, erv, eer, oor;
        logic [63:0] erd, resp;
        logic [60:0] line;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            slot = cyc % 8;
            erv  = rv_m[i][slot];
            eer  = erv & er_m[i][slot];
            erd  = erv ? rd_m[i][slot] : 64'h0;
            pend = 0;
            for (int s = 0; s < 8; s++) if (rv_m[i][s]) pend++;
            eg = req[i] && (held[i] >= GW[i]) && ((pend < MO[i]) || erv);
            chk($sformatf("gnt dev%0d cyc%0d", i, cyc), gnt[i], eg);
            chk($sformatf("rvalid dev%0d cyc%0d", i, cyc), rvalid[i], erv);
            chk($sformatf("err dev%0d cyc%0d", i, cyc), err[i], eer);
            chk($sformatf("rdata dev%0d cyc%0d", i, cyc), rdata[i], erd);
            if (gnt[i] && gn[i] < 32) begin
                gcyc[i][gn[i]] = cyc;
                gn[i]++;
            end
            if (rvalid[i]) begin
                if (rn[i] < 32) begin
                    rcyc[i][rn[i]] = cyc;
                    rn[i]++;
                end
                last_rd[i] = rdata[i];
                last_er[i] = err[i];
            end
            rv_m[i][slot] = 1'b0;
            acc[i] = eg;
            if (eg) begin
                line = addr[i][63:3];
                oor  = line >= 61'(DEPTH);
                resp = '0;
                if (!oor) begin
                    if (we[i]) begin
                        for (int k = 0; k < 8; k++)
                            if (be[i][k]) mem_m[i][line[3:0]][8*k +: 8] = wdata[i][8*k +: 8];
                    end else begin
                        resp = mem_m[i][line[3:0]];
                    end
                end
                nslot = (cyc + LAT[i]) % 8;
                rv_m[i][nslot] = 1'b1;
                er_m[i][nslot] = oor;
                rd_m[i][nslot] = resp;
                held[i] = 0;
            end else if (req[i]) begin
                held[i]++;
            end else begin
                held[i] = 0;
            end
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic drain(input int n);
        for (int j = 0; j < n; j++) tick();
    endtask

    // Hold a request on one instance until the model grants it.
    task automatic do_txn(input int i, input logic w, input logic [63:0] a, input logic [7:0] b,
                          input logic [63:0] d, input bit keep, output int waits);
        req[i] = 1'b1; we[i] = w; addr[i] = a; be[i] = b; wdata[i] = d;
        waits = 0;
        for (int n = 0; n < 40; n++) begin
            tick();
            if (acc[i]) break;
            waits++;
        end
        if (!acc[i]) begin
            n_cmp++;
            n_fail++;
            $error("FAIL txn_timeout dev%0d: no grant after %0d cycles, grant required", i, waits);
        end
        if (!keep) req[i] = 1'b0;
    endtask

    task automatic check_outputs_zero(input string tag);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("%s gnt dev%0d", tag, i), gnt[i], 1'b0);
            chk($sformatf("%s rvalid dev%0d", tag, i), rvalid[i], 1'b0);
            chk($sformatf("%s rdata dev%0d", tag, i), rdata[i], 64'h0);
            chk($sformatf("%s err dev%0d", tag, i), err[i], 1'b0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, completion required");
        $fatal(1);
    end

    initial begin
        int          w, k, base;
        logic [63:0] d, line0_u0;
        int          exp_g [4] = '{0, 1, 3, 4};
        int          exp_r [4] = '{3, 4, 6, 7};

        // Reset with requests asserted: grant must stay low
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            req[i] = 1'b1; we[i] = 1'b0; addr[i] = '0; be[i] = '0; wdata[i] = '0;
        end
        clear_model();
        clear_logs();
        line0_u0 = '0;
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        for (int i = 0; i < 3; i++) req[i] = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cyc = 0;

        // Preload every line of every instance
        for (int i = 0; i < 3; i++) begin
            for (int l = 0; l < DEPTH; l++) begin
                d = {$urandom, $urandom};
                if (i == 0 && l == 0) line0_u0 = d;
                do_txn(i, 1'b1, 64'(l * 8), 8'hFF, d, 1'b0, w);
            end
        end
        drain(6);

        // Zero-wait write then back-to-back read of line 5
        clear_logs();
        do_txn(0, 1'b1, 64'd40, 8'hFF, 64'h1122334455667788, 1'b1, w);
        chk("t1_write_grant_wait", 64'(w), 64'd0);
        do_txn(0, 1'b0, 64'd40, 8'h00, 64'h0, 1'b0, w);
        chk("t1_read_grant_wait", 64'(w), 64'd0);
        drain(3);
        chk("t1_read_data", last_rd[0], 64'h1122334455667788);
        chk("t1_read_err", last_er[0], 1'b0);
        chk("t1_read_latency", 64'(rcyc[0][1] - gcyc[0][1]), 64'd1);

        // Byte lanes on line 5
        do_txn(0, 1'b1, 64'd40, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, w);
        do_txn(0, 1'b1, 64'd40, 8'h0C, 64'h0, 1'b1, w);
        do_txn(0, 1'b0, 64'd40, 8'h00, 64'h0, 1'b0, w);
        drain(3);
        chk("t2_byte_lanes", last_rd[0], 64'hFFFF_FFFF_0000_FFFF);

        // Three grant wait states, two back-to-back requests
        clear_logs();
        base = cyc;
        do_txn(1, 1'b0, 64'd16, 8'h00, 64'h0, 1'b1, w);
        chk("t3_first_wait", 64'(w), 64'd3);
        do_txn(1, 1'b0, 64'd24, 8'h00, 64'h0, 1'b0, w);
        chk("t3_second_wait", 64'(w), 64'd3);
        drain(3);
        chk("t3_first_grant_cycle", 64'(gcyc[1][0] - base), 64'd3);
        chk("t3_second_grant_cycle", 64'(gcyc[1][1] - base), 64'd7);
        // be=0 write must leave line 4 intact (read checked by the model)
        do_txn(1, 1'b1, 64'd32, 8'h00, {$urandom, $urandom}, 1'b0, w);
        do_txn(1, 1'b0, 64'd32, 8'h00, 64'h0, 1'b0, w);
        drain(3);

        // Latency 3, two outstanding: four reads held back to back
        clear_logs();
        base = cyc;
        k = 0;
        req[2] = 1'b1; we[2] = 1'b0; addr[2] = 64'd0;
        for (int n = 0; n < 40; n++) begin
            tick();
            if (acc[2]) begin
                k++;
                if (k == 4) break;
                addr[2] = 64'(k * 8);
            end
        end
        req[2] = 1'b0;
        drain(6);
        chk("t4_grant_count", 64'(gn[2]), 64'd4);
        chk("t4_rvalid_count", 64'(rn[2]), 64'd4);
        for (int j = 0; j < 4; j++) begin
            chk($sformatf("t4_grant_cycle%0d", j), 64'(gcyc[2][j] - base), 64'(exp_g[j]));
            chk($sformatf("t4_rvalid_cycle%0d", j), 64'(rcyc[2][j] - base), 64'(exp_r[j]));
        end

        // Out-of-range writes: error response, RAM untouched
        do_txn(0, 1'b1, 64'(DEPTH * 8), 8'hFF, 64'hDEAD_BEEF_CAFE_F00D, 1'b0, w);
        drain(2);
        chk("t5_oor_err", last_er[0], 1'b1);
        chk("t5_oor_rdata", last_rd[0], 64'h0);
        do_txn(0, 1'b0, 64'd0, 8'h00, 64'h0, 1'b0, w);
        drain(2);
        chk("t5_line0_unchanged", last_rd[0], line0_u0);
        do_txn(0, 1'b1, 64'h8000_0000_0000_0028, 8'hFF, 64'h0123_4567_89AB_CDEF, 1'b0, w);
        drain(2);
        chk("t5_high_addr_err", last_er[0], 1'b1);
        do_txn(0, 1'b0, 64'd40, 8'h00, 64'h0, 1'b0, w);
        drain(2);
        chk("t5_line5_unchanged", last_rd[0], 64'hFFFF_FFFF_0000_FFFF);

        // Reset while responses are in flight on two instances
        do_txn(2, 1'b0, 64'd8, 8'h00, 64'h0, 1'b0, w);
        do_txn(0, 1'b0, 64'd40, 8'h00, 64'h0, 1'b0, w);
        #2 rst_n = 1'b0;
        #1;
        check_outputs_zero("midreset");
        clear_model();
        @(posedge clk); cyc++;
        @(posedge clk); cyc++;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); cyc++;
        #1;
        drain(6);
        do_txn(0, 1'b0, 64'd40, 8'h00, 64'h0, 1'b0, w);
        do_txn(2, 1'b0, 64'd40, 8'h00, 64'h0, 1'b0, w);
        drain(5);
        chk("t6_dev0_after_reset", last_rd[0], 64'hFFFF_FFFF_0000_FFFF);

        // Random traffic on all instances
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < 3; i++) begin
                req[i]   = ($urandom % 4) != 0;
                we[i]    = $urandom % 2;
                addr[i]  = 64'(($urandom % 20) * 8 + ($urandom % 8));
                be[i]    = 8'($urandom);
                wdata[i] = {$urandom, $urandom};
            end
            tick();
        end
        for (int i = 0; i < 3; i++) req[i] = 1'b0;
        drain(6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
